// File: rtl/conv_layer_seq.sv
// Layer sequencer: time-shares one 9x9 convolution engine across NUM_CH output
// channels, streaming the input map from RAM and scattering results per channel.
`timescale 1ns/1ps
module conv_layer_seq #(
  parameter int DATA_W  = 16,
  parameter int NUM_IN  = 9216,
  parameter int NUM_OUT = 7744,
  parameter int NUM_CH  = 4,
  parameter int CLR_CYC = 2,
  parameter int TIMEOUT = 4096,
  parameter int IN_AW   = 14,
  parameter int OUT_AW  = 15,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk_in,
  input  logic                     rst_n,
  input  logic                     go,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [CH_W-1:0]          ch_sel,
  output logic                     in_rd_en,
  output logic [IN_AW-1:0]         in_rd_addr,
  input  logic signed [DATA_W-1:0] in_rd_data,
  output logic                     conv_rst,
  output logic                     conv_start,
  output logic signed [DATA_W-1:0] conv_map_in,
  input  logic signed [DATA_W-1:0] conv_map_out,
  input  logic                     conv_save,
  output logic                     out_wr_en,
  output logic [OUT_AW-1:0]        out_wr_addr,
  output logic signed [DATA_W-1:0] out_wr_data
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CLR  = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_NEXT = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam int CC_W = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;

  localparam logic [IN_AW:0]     RD_END    = (IN_AW + 1)'(NUM_IN);
  localparam logic [13:0]        WR_END    = 14'(NUM_OUT);
  localparam logic [WD_W-1:0]    WD_LAST   = WD_W'(TIMEOUT - 1);
  localparam logic [CC_W-1:0]    CC_LAST   = CC_W'(CLR_CYC - 1);
  localparam logic [CH_W-1:0]    CH_LAST   = CH_W'(NUM_CH - 1);
  localparam logic [OUT_AW-1:0]  BASE_STEP = OUT_AW'(NUM_OUT);

  logic [2:0]        r_state;
  logic [CH_W-1:0]   r_ch;
  logic              r_err;
  logic [OUT_AW-1:0] r_base;
  logic [IN_AW:0]    r_rd_cnt;
  logic [13:0]       r_wr_cnt;
  logic [WD_W-1:0]   r_wdog;
  logic [CC_W-1:0]   r_clr_cnt;
  logic              r_vld_p1;
  logic              r_started;

  logic w_run;
  logic w_wr_full;
  logic w_rd_en;
  logic w_wr_en;
  logic w_timeout;

  assign w_run     = (r_state == S_RUN);
  assign w_wr_full = (r_wr_cnt == WR_END);
  assign w_rd_en   = w_run && (r_rd_cnt < RD_END);
  assign w_wr_en   = w_run && conv_save && !w_wr_full;
  // A save in the cycle the watchdog expires still counts as progress.
  assign w_timeout = w_run && !w_wr_full && !conv_save && (r_wdog == WD_LAST);

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ch      <= '0;
      r_err     <= 1'b0;
      r_base    <= '0;
      r_rd_cnt  <= '0;
      r_wr_cnt  <= '0;
      r_wdog    <= '0;
      r_clr_cnt <= '0;
      r_vld_p1  <= 1'b0;
      r_started <= 1'b0;
    end else begin
      // p0 -> p1: RAM read issued this cycle returns data next cycle
      r_vld_p1 <= w_rd_en;
      case (r_state)
        S_IDLE: begin
          if (go) begin
            r_state   <= S_CLR;
            r_ch      <= '0;
            r_err     <= 1'b0;
            r_base    <= '0;
            r_clr_cnt <= '0;
          end
        end
        S_CLR: begin
          r_rd_cnt  <= '0;
          r_wr_cnt  <= '0;
          r_wdog    <= '0;
          r_started <= 1'b0;
          if (r_clr_cnt == CC_LAST) r_state <= S_RUN;
          else                      r_clr_cnt <= r_clr_cnt + 1'b1;
        end
        S_RUN: begin
          r_started <= 1'b1;
          if (w_rd_en) r_rd_cnt <= r_rd_cnt + 1'b1;
          if (w_wr_en) r_wr_cnt <= r_wr_cnt + 1'b1;
          r_wdog <= conv_save ? '0 : r_wdog + 1'b1;
          if (w_wr_full) begin
            r_state <= S_NEXT;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_NEXT: begin
          r_clr_cnt <= '0;
          if (r_ch == CH_LAST) begin
            r_state <= S_DONE;
          end else begin
            r_ch    <= r_ch + 1'b1;
            r_base  <= r_base + BASE_STEP;
            r_state <= S_CLR;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign err         = r_err;
  assign ch_sel      = r_ch;
  assign in_rd_en    = w_rd_en;
  assign in_rd_addr  = w_rd_en ? r_rd_cnt[IN_AW-1:0] : '0;
  assign conv_rst    = (r_state == S_IDLE) || (r_state == S_CLR) || (r_state == S_DONE);
  // Engine runs from the first returned pixel until the last result lands, zero-fed past the map end.
  assign conv_start  = w_run && r_started && !w_wr_full;
  assign conv_map_in = r_vld_p1 ? in_rd_data : '0;
  assign out_wr_en   = w_wr_en;
  assign out_wr_addr = r_base + OUT_AW'(r_wr_cnt);
  assign out_wr_data = w_wr_en ? conv_map_out : '0;

endmodule

// File: doc/conv_layer_seq.md
Name: conv_layer_seq

Overview:
- Sequencer for one 9x9 convolution engine (96x96 in, 88x88 out). It time-shares that engine across NUM_CH output channels.
- Per channel it:
  - clears the engine;
  - streams the input map from a synchronous input RAM;
  - holds the engine's start high;
  - writes every saved result into a channel-strided region of the output RAM.
- Sits between the layer-level controller (go/done) and the engine plus its two buffers.

Parameters:
- NUM_IN, 9216, input pixels per map (96*96).
- NUM_OUT, 7744, output pixels per channel (88*88).
- NUM_CH, 4, output channels processed in sequence.
- CLR_CYC, 2, cycles engine clear is held per channel.
- TIMEOUT, 4096, max cycles in RUN without a save before abort.
- IN_AW, 14, input RAM address width.
- OUT_AW, 15, output RAM address width (must cover NUM_CH*NUM_OUT).

Ports:
- clk_in  in  1  clock.
- rst_n  in  1  reset: synchronous, active-low.
- go  in  1  start layer; sampled only in IDLE.
- busy  out  1  high from go-accept until DONE exits.
- done  out  1  one-cycle pulse at end of layer (normal or abort).
- err  out  1  sticky timeout flag; cleared on next accepted go.
- ch_sel  out  log2(NUM_CH)  current channel; selects the engine's kernel/bias bank.
- in_rd_en  out  1  input RAM read enable.
- in_rd_addr  out  IN_AW  input RAM address.
- in_rd_data  in  16  signed pixel; valid 1 cycle after in_rd_en.
- conv_rst  out  1  engine clear, active-high.
- conv_start  out  1  engine start/clock-enable.
- conv_map_in  out  16  pixel to engine.
- conv_map_out  in  16  engine result.
- conv_save  in  1  engine result valid.
- out_wr_en  out  1  output RAM write enable.
- out_wr_addr  out  OUT_AW  output RAM address.
- out_wr_data  out  16  output RAM data.

Behaviour:
- Reset values (rst_n=0 at a clock edge):
  - state=IDLE.
  - busy=0, done=0, err=0, ch_sel=0.
  - in_rd_en=0, in_rd_addr=0, conv_start=0, conv_map_in=0.
  - out_wr_en=0, out_wr_addr=0, out_wr_data=0.
  - conv_rst=1.
  - Reset mid-operation aborts immediately; there is no done pulse.
- IDLE:
  - conv_rst=1.
  - go=1 -> CLR; busy=1, ch_sel=0, err=0, base=0.
- CLR:
  - conv_rst=1 for exactly CLR_CYC cycles.
  - Clears rd_cnt, wr_cnt and the watchdog, then -> RUN.
- RUN, read side:
  - conv_rst=0.
  - Cycles 0..NUM_IN-1 of RUN: in_rd_en=1, in_rd_addr=rd_cnt.
  - in_rd_en=0 once rd_cnt reaches NUM_IN.
- RUN, engine feed:
  - Registered rd_valid = in_rd_en delayed 1 cycle.
  - conv_map_in = rd_valid ? in_rd_data : 0 (combinational from in_rd_data).
  - conv_start rises in RUN cycle 1, the same cycle as the first valid pixel.
  - conv_start stays high continuously, zero-fed after the input ends, until wr_cnt==NUM_OUT.
- RUN, write side:
  - out_wr_en = conv_save && wr_cnt<NUM_OUT.
  - out_wr_addr = base + wr_cnt; out_wr_data = conv_map_out (combinational).
  - wr_cnt increments on each write.
  - Saves arriving after wr_cnt==NUM_OUT are ignored.
- RUN exit:
  - When wr_cnt==NUM_OUT: conv_start=0 from the next cycle, -> NEXT.
- NEXT (1 cycle):
  - If ch_sel==NUM_CH-1 -> DONE.
  - Else ch_sel+1, base+=NUM_OUT (adder, no multiplier), -> CLR.
- Watchdog:
  - Counts RUN cycles; zeroed on every conv_save.
  - Reaching TIMEOUT -> err=1, conv_start=0, -> DONE.
- DONE (1 cycle):
  - done=1, busy=0 on exit, conv_rst=1, -> IDLE.
  - go during DONE is ignored.
- go while busy is ignored.
- go held high in IDLE after DONE starts a new layer.
- Widths:
  - rd_cnt is IN_AW+1 bits so it can hold NUM_IN without wrap.
  - wr_cnt is 14 bits.
  - base+wr_cnt never exceeds NUM_CH*NUM_OUT-1.

Test Plan:
- Reset mid-RUN: rst_n=0 during channel 1 -> next cycle shows state IDLE, conv_rst=1, busy=0, no done, all RAM enables 0.
- Nominal layer with a behavioural engine model (save after pipeline, 88 of every 96 pixels), NUM_CH=4:
  - out RAM gets exactly 30976 writes, addresses 0..30975 each exactly once;
  - ch_sel steps 0,1,2,3;
  - exactly one done pulse; err=0.
- Read timing: first RUN cycle in_rd_addr=0, in_rd_en=1.
  - Next cycle conv_start=1 and conv_map_in=RAM[0].
  - After address 9215, in_rd_en=0 and conv_map_in=0 while conv_start stays 1.
- Channel boundary: 7744th save of ch0 writes addr 7743.
  - conv_start drops, conv_rst=1 for exactly 2 cycles.
  - ch1's first write goes to addr 7744.
- Extra save after wr_cnt==7744 in the same cycle as the RUN exit -> no write.
- Timeout: engine model never asserts save -> after 4096 RUN cycles err=1, done pulses once, busy=0.
  - Next go clears err.
- go pulsed while busy and during DONE -> no effect on sequence or counts.
